// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, carry-chained ADC/SBB,
// logic ops, an iterative shift-add multiplier and a persistent {Z,C,V,S} flag register.
module alu_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    // Multiply step counter runs 0..WIDTH-1
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic                 ready_en_q;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic [3:0]           flags_q, flags_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic                 is_mul;
    logic                 cin;
    logic [WIDTH:0]       ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   acc_step;

    assign in_ready  = ready_en_q && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (op == 3'd7);
    assign cin       = flags_q[2];
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

    // Single-cycle datapath: result and C/V for every op except MUL
    always_comb begin
        ext     = '0;
        alu_res = b;
        alu_c   = cin;
        alu_v   = 1'b0;
        case (op)
            3'd1, 3'd3: begin
                ext     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == 3'd3) & cin};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2, 3'd4: begin
                // Bit WIDTH of the extended difference is the borrow out
                ext     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == 3'd4) & cin};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            3'd5:    alu_res = a & b;
            3'd6:    alu_res = a | b;
            default: alu_res = b;
        endcase
    end

    // Next-state, multiplier step and output register loading
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        flags_d     = {(alu_res == '0), alu_c, alu_v, alu_res[WIDTH-1]};
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last step's sum is loaded directly so latency stays WIDTH+1 edges
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d    = acc_step[WIDTH-1:0];
                    result_hi_d = acc_step[2*WIDTH-1:WIDTH];
                    flags_d     = {(acc_step == '0),
                                   (|acc_step[2*WIDTH-1:WIDTH]),
                                   (|acc_step[2*WIDTH-1:WIDTH]),
                                   acc_step[2*WIDTH-1]};
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
